// File: rtl/word_to_hex_stream.sv
// Hex dump streamer: each accepted word leaves as WIDTH/4 nibble cells, MSB first,
// optionally followed by one space cell, with a text cursor that wraps at COLS x ROWS.
module word_to_hex_stream #(
  parameter int WIDTH = 32,
  parameter int COLS  = 80,
  parameter int ROWS  = 30,
  parameter int SEP   = 1
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         in_word,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [3:0]               out_nibble,
  output logic                     out_space,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(COLS)-1:0]  out_col,
  output logic [$clog2(ROWS)-1:0]  out_row,
  output logic                     busy
);

  localparam int NIBS  = WIDTH / 4;
  localparam int CNT_W = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(NIBS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_EMIT  = 2'd1;
  localparam logic [1:0] ST_SPACE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0] cnt;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             xfer;

  // Outputs decode straight from registered state, so reset reaches them without a clock.
  assign in_ready   = (state == ST_IDLE);
  assign busy       = ~in_ready;
  assign out_valid  = (state == ST_EMIT) || (state == ST_SPACE);
  assign out_space  = (state == ST_SPACE);
  assign out_nibble = (state == ST_EMIT) ? shift_reg[WIDTH-1 -: 4] : 4'h0;
  assign out_col    = col;
  assign out_row    = row;
  assign xfer       = out_valid & out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            shift_reg <= in_word;
            cnt       <= CNT_LOAD;
            state     <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            shift_reg <= shift_reg << 4;
            cnt       <= cnt - CNT_W'(1);
            if (cnt == '0) state <= (SEP != 0) ? ST_SPACE : ST_IDLE;
          end
        end
        ST_SPACE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Cursor advances once per accepted cell; clear wins over a same-edge advance.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (xfer) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_word_to_hex_stream.sv
// Randomized bench for word_to_hex_stream: a queue of expected cells plus a cell
// counter for the cursor, checked on every falling edge.
module tb_word_to_hex_stream;

  localparam int WIDTH = 32;
  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int SEP   = 1;
  localparam int NIBS  = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rstb;
  logic             clear;
  logic [WIDTH-1:0] in_word;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       out_nibble;
  logic             out_space;
  logic             out_valid;
  logic             out_ready;
  logic [6:0]       out_col;
  logic [4:0]       out_row;
  logic             busy;

  logic       b_clear;
  logic [3:0] b_in_word;
  logic       b_in_valid;
  logic       b_in_ready;
  logic [3:0] b_out_nibble;
  logic       b_out_space;
  logic       b_out_valid;
  logic       b_out_ready;
  logic [1:0] b_out_col;
  logic [0:0] b_out_row;
  logic       b_busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  word_to_hex_stream #(.WIDTH(WIDTH), .COLS(COLS), .ROWS(ROWS), .SEP(SEP)) dut (
    .clk(clk), .rstb(rstb), .clear(clear), .in_word(in_word), .in_valid(in_valid),
    .in_ready(in_ready), .out_nibble(out_nibble), .out_space(out_space),
    .out_valid(out_valid), .out_ready(out_ready), .out_col(out_col),
    .out_row(out_row), .busy(busy)
  );

  word_to_hex_stream #(.WIDTH(4), .COLS(4), .ROWS(2), .SEP(0)) dut_b (
    .clk(clk), .rstb(rstb), .clear(b_clear), .in_word(b_in_word), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .out_nibble(b_out_nibble), .out_space(b_out_space),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_col(b_out_col),
    .out_row(b_out_row), .busy(b_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending cells {space, nibble} and cells since last clear.
  logic [4:0] exp_q[$];
  int         cells = 0;
  bit         model_idle;

  always @(negedge clk) begin
    if (!rstb) begin
      exp_q.delete();
      cells = 0;
    end else begin
      model_idle = (exp_q.size() == 0);
      check("in_ready", {31'd0, in_ready}, {31'd0, model_idle});
      check("busy", {31'd0, busy}, {31'd0, !model_idle});
      check("out_valid", {31'd0, out_valid}, {31'd0, !model_idle});
      if (!model_idle) begin
        check("nibble", {28'd0, out_nibble}, {28'd0, exp_q[0][3:0]});
        check("space", {31'd0, out_space}, {31'd0, exp_q[0][4]});
        check("col", {25'd0, out_col}, cells % COLS);
        check("row", {27'd0, out_row}, (cells / COLS) % ROWS);
      end
      if (clear) cells = 0;
      else if (!model_idle && out_ready) cells++;
      if (!model_idle && out_ready) void'(exp_q.pop_front());
      if (model_idle && in_valid) begin
        for (int i = 0; i < NIBS; i++)
          exp_q.push_back({1'b0, 4'((in_word >> (4 * (NIBS - 1 - i))) & 32'hF)});
        if (SEP != 0) exp_q.push_back(5'h10);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_space"}, {31'd0, out_space}, 32'd0);
    check({tag, "_nibble"}, {28'd0, out_nibble}, 32'd0);
    check({tag, "_col"}, {25'd0, out_col}, 32'd0);
    check({tag, "_row"}, {27'd0, out_row}, 32'd0);
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send_word(input logic [WIDTH-1:0] w);
    int k = 0;
    in_valid = 1'b1;
    in_word  = w;
    while (!in_ready && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check("accept_wait", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (!in_ready && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check("wait_idle", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rstb = 1'b0; clear = 1'b0; in_word = '0; in_valid = 1'b0; out_ready = 1'b1;
    b_clear = 1'b0; b_in_word = '0; b_in_valid = 1'b0; b_out_ready = 1'b1;
    #1;
    check_reset_outputs("rst0");
    @(posedge clk); #1;
    rstb = 1'b1;

    // Narrow instance: 0xF then 0x0 with in_valid held, one IDLE cycle between cells.
    b_in_valid = 1'b1; b_in_word = 4'hF;
    @(negedge clk);
    check("b_ready0", {31'd0, b_in_ready}, 32'd1);
    @(posedge clk); #1;
    b_in_word = 4'h0;
    @(negedge clk);
    check("b_valid_f", {31'd0, b_out_valid}, 32'd1);
    check("b_nib_f", {28'd0, b_out_nibble}, 32'hF);
    check("b_col_f", {30'd0, b_out_col}, 32'd0);
    @(negedge clk);
    check("b_idle_gap", {31'd0, b_out_valid}, 32'd0);
    check("b_ready_gap", {31'd0, b_in_ready}, 32'd1);
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    @(negedge clk);
    check("b_valid_0", {31'd0, b_out_valid}, 32'd1);
    check("b_nib_0", {28'd0, b_out_nibble}, 32'h0);
    check("b_space_0", {31'd0, b_out_space}, 32'd0);
    check("b_col_0", {30'd0, b_out_col}, 32'd1);
    @(negedge clk);
    check("b_done_valid", {31'd0, b_out_valid}, 32'd0);
    check("b_done_col", {30'd0, b_out_col}, 32'd2);
    @(posedge clk); #1;

    // 0xDEADBEEF at full rate: ten cycles per word.
    send_word(32'hDEADBEEF);
    repeat (8) @(posedge clk);
    #1;
    check("lat_busy", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    check("lat_ready", {31'd0, in_ready}, 32'd1);
    check("lat_col", {25'd0, out_col}, 32'd9);

    // 0x0123ABCD with out_ready toggling every cycle.
    in_valid = 1'b1; in_word = 32'h0123ABCD;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (!in_ready) in_valid = 1'b0;
      out_ready = !out_ready;
    end
    out_ready = 1'b1;
    wait_idle(40);

    // Random traffic, back-pressure and occasional clears.
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      in_valid  = 1'($urandom_range(0, 1));
      in_word   = $urandom;
      out_ready = ($urandom_range(0, 9) < 7);
      clear     = ($urandom_range(0, 49) == 0);
    end
    in_valid = 1'b0; clear = 1'b0; out_ready = 1'b1;
    wait_idle(50);

    // 267 words -> 2403 cells: wraps columns and rows, ends at (3,0).
    clear_pulse();
    for (int w = 0; w < 267; w++) send_word($urandom);
    wait_idle(50);
    check("wrap_col", {25'd0, out_col}, 32'd3);
    check("wrap_row", {27'd0, out_row}, 32'd0);

    // Clear on the same edge as an EMIT transfer at (5,2).
    clear_pulse();
    in_valid = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      @(posedge clk); #1;
      in_word = $urandom;
      if (out_valid && !out_space && out_col == 7'd5 && out_row == 5'd2) begin
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check("clr_col", {25'd0, out_col}, 32'd0);
        check("clr_row", {27'd0, out_row}, 32'd0);
        check("clr_valid", {31'd0, out_valid}, 32'd1);
        found = 1'b1;
      end
    end
    check("clr_found", {31'd0, found}, 32'd1);
    in_valid = 1'b0;
    wait_idle(50);

    // Asynchronous reset during the third nibble of a word.
    send_word(32'h89ABCDEF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_nib", {28'd0, out_nibble}, 32'hA);
    #2;
    rstb = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(posedge clk);
    @(posedge clk); #1;
    rstb = 1'b1;
    check("rel_ready", {31'd0, in_ready}, 32'd1);
    send_word(32'h00000001);
    wait_idle(50);
    check("rel_col", {25'd0, out_col}, 32'd9);
    check("rel_row", {27'd0, out_row}, 32'd0);

    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
